// File: rtl/aud_rec_pkg.sv
// Shared types and defaults for the audio capture path (WM8731 ADC -> SRAM).
package aud_rec_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_LR,
    SHIFT,
    WRITE,
    PAUSED
  } state_t;

  localparam int ADDR_W_DEF = 20;
  localparam int DATA_W_DEF = 16;
  localparam int I2S_DELAY  = 1;

endpackage

// File: rtl/i2s_rx_shift.sv
// I2S receive front end: frame-edge detect, MSB-first shift register, sample_valid pulse.
// Define AUD_RECORDER_STEREO_AVG_EN to also capture the right channel and emit (L+R)>>>1.
module i2s_rx_shift
  import aud_rec_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              bclk,
  input  logic              daclrck,
  input  logic              adclrck,
  input  logic              adcdat,
  output logic              frame_start,
  output logic              sample_valid,
  output logic [DATA_W-1:0] sample
);

  localparam int CW = $clog2(DATA_W);

  logic              lrc_q;
  logic              l_active;
  logic [CW-1:0]     l_cnt;
  logic [DATA_W-1:0] l_shift;
  logic              l_last;
  logic              valid_reg;

  // The edge cycle itself is the one-bit I2S delay slot; bits follow on the next edges.
  assign frame_start = ~adclrck & lrc_q;
  assign l_last      = l_active && (l_cnt == CW'(DATA_W - 1));

  always_ff @(posedge bclk or posedge daclrck) begin
    if (daclrck) begin
      lrc_q    <= 1'b0;
      l_active <= 1'b0;
      l_cnt    <= '0;
      l_shift  <= '0;
    end else begin
      lrc_q <= adclrck;
      if (frame_start) begin
        l_active <= 1'b1;
        l_cnt    <= '0;
      end else if (l_active) begin
        l_shift <= {l_shift[DATA_W-2:0], adcdat};
        l_cnt   <= l_cnt + 1'b1;
        if (l_last) l_active <= 1'b0;
      end
    end
  end

`ifdef AUD_RECORDER_STEREO_AVG_EN
  logic                r_active;
  logic [CW-1:0]       r_cnt;
  logic [DATA_W-1:0]   r_shift;
  logic                r_last;
  logic                r_start;
  logic signed [DATA_W:0] sum;

  assign r_start = adclrck & ~lrc_q;
  assign r_last  = r_active && (r_cnt == CW'(DATA_W - 1));

  always_ff @(posedge bclk or posedge daclrck) begin
    if (daclrck) begin
      r_active <= 1'b0;
      r_cnt    <= '0;
      r_shift  <= '0;
    end else if (r_start) begin
      r_active <= 1'b1;
      r_cnt    <= '0;
    end else if (r_active) begin
      r_shift <= {r_shift[DATA_W-2:0], adcdat};
      r_cnt   <= r_cnt + 1'b1;
      if (r_last) r_active <= 1'b0;
    end
  end

  // Sign-extended 17-bit sum cannot overflow; dropping the LSB is the arithmetic halving.
  assign sum    = $signed({l_shift[DATA_W-1], l_shift}) + $signed({r_shift[DATA_W-1], r_shift});
  assign sample = sum[DATA_W:1];

  always_ff @(posedge bclk or posedge daclrck) begin
    if (daclrck) valid_reg <= 1'b0;
    else         valid_reg <= r_last;
  end
`else
  assign sample = l_shift;

  always_ff @(posedge bclk or posedge daclrck) begin
    if (daclrck) valid_reg <= 1'b0;
    else         valid_reg <= l_last;
  end
`endif

  assign sample_valid = valid_reg;

endmodule

// File: rtl/aud_recorder.sv
// Capture FSM: records ADC samples to consecutive SRAM addresses with start/pause/stop control.
// Stereo averaging is selected by AUD_RECORDER_STEREO_AVG_EN inside i2s_rx_shift.
module aud_recorder
  import aud_rec_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              i_bclk,
  input  logic              daclrck,
  input  logic              i_adclrck,
  input  logic              i_adcdat,
  input  logic              i_start,
  input  logic              i_pause,
  input  logic              i_stop,
  output logic [ADDR_W-1:0] o_address,
  output logic [DATA_W-1:0] o_data,
  output logic              o_we,
  output logic [ADDR_W:0]   o_len,
  output logic              o_busy,
  output logic              o_full
);

  state_t            state_reg, state_next;
  logic              pend_reg, pend_next;
  logic [ADDR_W:0]   len_reg;
  logic              frame_start;
  logic              sample_valid;
  logic [DATA_W-1:0] sample;
  logic              load_write;
  logic              commit;
  logic              clear;
  logic              last;

  i2s_rx_shift #(.DATA_W(DATA_W)) u_rx (
    .bclk         (i_bclk),
    .daclrck      (daclrck),
    .adclrck      (i_adclrck),
    .adcdat       (i_adcdat),
    .frame_start  (frame_start),
    .sample_valid (sample_valid),
    .sample       (sample)
  );

  // The sample count doubles as the next write address.
  assign last   = &len_reg[ADDR_W-1:0];
  assign o_len  = len_reg;
  assign o_busy = (state_reg == WAIT_LR) || (state_reg == SHIFT) || (state_reg == WRITE);

  always_ff @(posedge i_bclk or posedge daclrck) begin
    if (daclrck) state_reg <= IDLE;
    else         state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    pend_next  = pend_reg;
    load_write = 1'b0;
    commit     = 1'b0;
    clear      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!i_stop && i_start) begin
          clear      = 1'b1;
          state_next = WAIT_LR;
        end
      end
      WAIT_LR: begin
        if (i_stop)           state_next = IDLE;
        else if (i_pause)     state_next = PAUSED;
        else if (frame_start) state_next = SHIFT;
      end
      SHIFT: begin
        if (i_stop) begin
          state_next = IDLE;
        end else begin
          if (i_pause) pend_next = 1'b1;
          if (sample_valid) begin
            load_write = 1'b1;
            state_next = WRITE;
          end
        end
      end
      WRITE: begin
        commit = 1'b1;
        if (last || i_stop)          state_next = IDLE;
        else if (pend_reg || i_pause) state_next = PAUSED;
        else                          state_next = WAIT_LR;
      end
      PAUSED: begin
        if (i_stop)                   state_next = IDLE;
        else if (!i_pause && i_start) state_next = WAIT_LR;
      end
      default: state_next = IDLE;
    endcase
    if (state_next == IDLE || state_next == WAIT_LR || state_next == PAUSED) pend_next = 1'b0;
  end

  always_ff @(posedge i_bclk or posedge daclrck) begin
    if (daclrck) begin
      pend_reg  <= 1'b0;
      len_reg   <= '0;
      o_address <= '0;
      o_data    <= '0;
      o_we      <= 1'b0;
      o_full    <= 1'b0;
    end else begin
      pend_reg <= pend_next;
      o_we     <= load_write;
      if (load_write) begin
        o_address <= len_reg[ADDR_W-1:0];
        o_data    <= sample;
      end
      if (clear) begin
        len_reg <= '0;
        o_full  <= 1'b0;
      end else if (commit) begin
        len_reg <= len_reg + 1'b1;
        if (last) o_full <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_aud_recorder.sv
// Directed bench for aud_recorder (ADDR_W=4): capture, pause, stop, full and reset scenarios.
module tb_aud_recorder;

  logic        bclk = 1'b0;
  logic        daclrck;
  logic        adclrck;
  logic        adcdat;
  logic        i_start, i_pause, i_stop;
  logic [3:0]  o_address;
  logic [15:0] o_data;
  logic        o_we;
  logic [4:0]  o_len;
  logic        o_busy;
  logic        o_full;

  int total = 0;
  int bad   = 0;

  int          we_cnt, we_at;
  logic [3:0]  we_addr;
  logic [15:0] we_data;
  logic        busy_after;
  logic        rst_busy, rst_we, rst_full;
  logic [3:0]  rst_addr;
  logic [15:0] rst_data;

  aud_recorder #(.ADDR_W(4), .DATA_W(16)) dut (
    .i_bclk    (bclk),
    .daclrck   (daclrck),
    .i_adclrck (adclrck),
    .i_adcdat  (adcdat),
    .i_start   (i_start),
    .i_pause   (i_pause),
    .i_stop    (i_stop),
    .o_address (o_address),
    .o_data    (o_data),
    .o_we      (o_we),
    .o_len     (o_len),
    .o_busy    (o_busy),
    .o_full    (o_full)
  );

  always #5 bclk = ~bclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Idle cycles with ADCLRCK high (right half); optional start pulse on the first cycle.
  task automatic idle(input int n, input bit start);
    for (int i = 0; i < n; i++) begin
      @(negedge bclk);
      i_start = start && (i == 0);
      i_pause = 1'b0;
      i_stop  = 1'b0;
      adclrck = 1'b1;
      adcdat  = 1'b0;
    end
  endtask

  // One 32-bit I2S frame; cycle k feeds posedge E_k, E0 is the left-frame-start edge.
  // sel at cycle pk: 1 pause, 2 stop, 3 stop+pause, 5 async reset pulse.
  task automatic frame(input logic [15:0] l, input int pk, input int sel);
    we_cnt = 0;
    we_at  = -1;
    for (int k = 0; k < 32; k++) begin
      @(negedge bclk);
      if (k > 0 && o_we === 1'b1) begin
        we_cnt++;
        if (we_at < 0) begin
          we_at   = k - 1;
          we_addr = o_address;
          we_data = o_data;
        end
      end
      if (k == pk + 1) busy_after = o_busy;
      i_start = 1'b0;
      i_pause = 1'b0;
      i_stop  = 1'b0;
      daclrck = 1'b0;
      adclrck = (k >= 16);
      adcdat  = (k >= 1 && k <= 16) ? l[16-k] : 1'b0;
      if (k == pk) begin
        case (sel)
          1: i_pause = 1'b1;
          2: i_stop  = 1'b1;
          3: begin i_stop = 1'b1; i_pause = 1'b1; end
          5: begin
            daclrck = 1'b1;
            #1;
            rst_busy = o_busy;
            rst_we   = o_we;
            rst_addr = o_address;
            rst_data = o_data;
            rst_full = o_full;
          end
          default: ;
        endcase
      end
    end
  endtask

  initial begin
    daclrck = 1'b1;
    adclrck = 1'b1;
    adcdat  = 1'b0;
    i_start = 1'b0;
    i_pause = 1'b0;
    i_stop  = 1'b0;
    repeat (3) @(negedge bclk);
    check("rst_we", o_we, 0);
    check("rst_addr", o_address, 0);
    check("rst_data", o_data, 0);
    check("rst_len", o_len, 0);
    check("rst_busy", o_busy, 0);
    check("rst_full", o_full, 0);
    daclrck = 1'b0;

    // Three-sample capture
    idle(2, 1'b1);
    idle(1, 1'b0);
    check("start_busy", o_busy, 1);
    frame(16'h8001, -5, 0);
    check("s0_cnt", we_cnt, 1);
    check("s0_lat", we_at, 17);
    check("s0_addr", we_addr, 0);
    check("s0_data", we_data, 16'h8001);
    frame(16'h7FFE, -5, 0);
    check("s1_addr", we_addr, 1);
    check("s1_data", we_data, 16'h7FFE);
    check("s1_lat", we_at, 17);
    frame(16'h1234, -5, 0);
    check("s2_addr", we_addr, 2);
    check("s2_data", we_data, 16'h1234);
    check("s2_cnt", we_cnt, 1);
    check("len3", o_len, 3);

    // Stop from WAIT_LR, then pause mid-sample
    idle(1, 1'b0);
    i_stop = 1'b1;
    idle(1, 1'b0);
    idle(1, 1'b0);
    check("stopw_busy", o_busy, 0);
    check("stopw_len", o_len, 3);
    idle(2, 1'b1);
    frame(16'hA5A5, 8, 1);
    check("pause_busy_inflight", busy_after, 1);
    check("pause_cnt", we_cnt, 1);
    check("pause_addr", we_addr, 0);
    check("pause_data", we_data, 16'hA5A5);
    check("paused_busy", o_busy, 0);
    for (int f = 0; f < 4; f++) begin
      frame(16'hFFFF, -5, 0);
      check("paused_no_we", we_cnt, 0);
    end
    check("paused_len", o_len, 1);
    idle(2, 1'b1);
    frame(16'h0F0F, -5, 0);
    check("resume_addr", we_addr, 1);
    check("resume_data", we_data, 16'h0F0F);
    check("resume_len", o_len, 2);

    // Stop mid-sample at bit 10
    frame(16'h5555, 10, 2);
    check("stop_busy_next", busy_after, 0);
    check("stop_no_we", we_cnt, 0);
    check("stop_len", o_len, 2);
    check("stop_addr_hold", o_address, 1);

    // Simultaneous stop and pause: must land in IDLE, so start clears the count
    idle(2, 1'b1);
    frame(16'h1357, -5, 0);
    check("sp_pre_len", o_len, 1);
    frame(16'h2468, 5, 3);
    check("sp_busy", busy_after, 0);
    check("sp_no_we", we_cnt, 0);
    idle(1, 1'b1);
    idle(1, 1'b0);
    check("sp_idle_restart_len", o_len, 0);

    // Fill all 16 addresses
    for (int i = 0; i < 16; i++) begin
      frame({4'(i), 12'hC3A}, -5, 0);
      check("full_addr", we_addr, i);
      check("full_data", we_data, {4'(i), 12'hC3A});
      if (i == 14) begin
        check("prefull_flag", o_full, 0);
        check("prefull_len", o_len, 15);
      end
    end
    check("full_flag", o_full, 1);
    check("full_len", o_len, 16);
    check("full_busy", o_busy, 0);
    frame(16'hBEEF, -5, 0);
    check("full_ignore", we_cnt, 0);
    check("full_hold", o_full, 1);

    // Asynchronous reset during SHIFT
    idle(1, 1'b1);
    idle(1, 1'b0);
    check("restart_full_clr", o_full, 0);
    check("restart_busy", o_busy, 1);
    frame(16'hDEAD, 8, 5);
    check("arst_busy", rst_busy, 0);
    check("arst_we", rst_we, 0);
    check("arst_addr", rst_addr, 0);
    check("arst_data", rst_data, 0);
    check("arst_full", rst_full, 0);
    check("arst_no_we", we_cnt, 0);
    check("arst_len", o_len, 0);
    idle(2, 1'b1);
    frame(16'h3C3C, -5, 0);
    check("post_rst_addr", we_addr, 0);
    check("post_rst_data", we_data, 16'h3C3C);
    check("post_rst_lat", we_at, 17);
    check("post_rst_len", o_len, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aud_recorder.md
Name: aud_recorder

Overview:
- Capture-side counterpart of the playback DSP path.
- Deserialises the codec ADC I2S stream, one 16-bit sample per ADCLRCK frame.
- Writes each sample to SRAM at consecutive addresses from 0, so the playback block can later read them back.
- Sits between the WM8731 ADC pins and the SRAM write port. Driven by top-level start/pause/stop controls.

Parameters:
- ADDR_W, 20, SRAM word-address width; capacity is 2^ADDR_W samples.
- DATA_W, 16, sample width in bits (MSB-first, two's complement).

Ports:
- i_bclk  input  1  codec bit clock; all logic on its rising edge.
- daclrck  input  1  reset, asynchronous, active-high.
- i_adclrck  input  1  ADC frame clock; low = left channel.
- i_adcdat  input  1  ADC serial data.
- i_start  input  1  one-cycle pulse; start (from IDLE) or resume (from PAUSED).
- i_pause  input  1  one-cycle pulse; pause at the next sample boundary.
- i_stop  input  1  one-cycle pulse; abort recording.
- o_address  output  ADDR_W  SRAM write address.
- o_data  output  DATA_W  SRAM write data.
- o_we  output  1  SRAM write strobe, one cycle per sample.
- o_len  output  ADDR_W+1  number of samples written in the current/last take.
- o_busy  output  1  high in WAIT_LR, SHIFT, WRITE.
- o_full  output  1  sticky; set when the last address has been written.

Behaviour:
- Reset (daclrck=1, async): state IDLE; all outputs and internal counters are 0.
- A registered copy of i_adclrck (lrc_q) provides edge detection. A left-frame start is a rising bclk where i_adclrck=0 and lrc_q=1.
- States:
  - IDLE: on i_start, clear o_len, address and o_full, then go to WAIT_LR.
  - WAIT_LR: on a left-frame start, go to SHIFT with bit counter = 0. The edge cycle itself is the I2S 1-bit delay slot.
  - SHIFT: on each of the next 16 rising edges, shift i_adcdat into the LSB (MSB arrives first). After the 16th bit, go to WRITE.
  - WRITE: drive o_we=1, o_data=sample, o_address=addr for exactly one cycle. Then addr++ and o_len++.
    - If addr was 2^ADDR_W-1: set o_full and go to IDLE.
    - Else if a pause is pending: go to PAUSED.
    - Else: go to WAIT_LR.
  - PAUSED: o_we=0. On i_start, go to WAIT_LR; the address is retained and the next sample is appended.
- Latency: o_we rises 17 bclk cycles after the left-frame-start edge cycle.
- Pause: i_pause in WAIT_LR goes to PAUSED immediately. i_pause in SHIFT sets a pause-pending flag; the sample in flight still completes and is written.
- Stop: i_stop from any state goes to IDLE next cycle.
  - A partial sample in SHIFT is discarded, with no o_we.
  - o_len and o_address hold their last values.
  - Stop in WRITE lets that single o_we cycle complete, then goes to IDLE.
- Priority for simultaneous pulses: stop > pause > start.
- i_start is ignored in WAIT_LR, SHIFT and WRITE.
- Right-channel bits are ignored (unless the optional feature is compiled in).
- Between writes, o_address, o_data and o_we hold; o_we is 0 outside WRITE.
- Reset mid-operation: immediate return to IDLE, outputs 0, no o_we glitch.

Optional Feature:
- Macro: AUD_RECORDER_STEREO_AVG_EN.
- Defined:
  - Also deserialise the right channel, starting one bit after the i_adclrck rising edge.
  - WRITE follows the 16th right bit, with o_data = (L + R) >>> 1 computed in 17-bit signed arithmetic. No overflow is possible.
  - Latency becomes 17 cycles after the right-frame-start edge.
  - Pause and stop apply to the stereo pair as one sample.
- Undefined: left channel only, as specified above.

Decomposition:
- Package aud_rec_pkg:
  - state enum {IDLE, WAIT_LR, SHIFT, WRITE, PAUSED};
  - constants ADDR_W_DEF=20, DATA_W_DEF=16, I2S_DELAY=1.
- Sub-module i2s_rx_shift:
  - edge detect plus 16-bit shift register and bit counter;
  - outputs a sample_valid pulse and the sample;
  - the FSM/address logic stays in aud_recorder.

Test Plan:
- Capture three samples: reset, start, left frames carrying 16'h8001, 16'h7FFE, 16'h1234 -> o_we pulses 3 times at addresses 0,1,2 with those data; o_len=3; each o_we 17 cycles after the edge.
- Pause mid-sample: pause at bit 8 of sample 16'hA5A5 -> 16'hA5A5 still written at addr 0, then PAUSED with no o_we over 4 frames; start -> next sample 16'h0F0F at addr 1.
- Stop mid-sample: stop at bit 10 -> no o_we; o_len unchanged; IDLE; o_busy=0 next cycle.
- Full: ADDR_W=4, record 16 frames -> last o_we at addr 15; o_full=1; o_len=16; IDLE; frame 17 ignored.
- Simultaneous stop and pause in SHIFT -> IDLE, not PAUSED.
- Reset mid-operation: daclrck high in SHIFT -> all outputs 0 asynchronously; after release, start re-records from addr 0.
